td4_io_port: RTL and testbench

Peripheral block at the far end of the TD4 4-bit I/O ports. It drives the CPU's `in` port from a host-written holding register. It also watches the CPU's `out` port and queues every value change into a FIFO, which a host drains over a valid/ready handshake. The block sits beside `td4` in the top level, so CPU programs can be exercised and observed without probing internal state.

---
 rtl/td4_io_pkg.sv | 17 +
 rtl/td4_io_fifo.sv | 55 +++++
 rtl/td4_io_port.sv | 97 +++++++++
 tb/tb_td4_io_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_io_pkg.sv
// Shared types and defaults for the TD4 I/O port peripheral.
// TD4_IO_TIMESTAMP_EN adds a timestamp field to each capture entry.
package td4_io_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        nibble_t data;
`ifdef TD4_IO_TIMESTAMP_EN
        logic [TS_W_DEF-1:0] ts;
`endif
    } cap_entry_t;

endpackage

// File: rtl/td4_io_fifo.sv
// Synchronous circular-buffer FIFO of cap_entry_t with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module td4_io_fifo
    import td4_io_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  cap_entry_t               wdata,
    input  logic                     pop,
    input  logic                     clr,
    output cap_entry_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cap_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/td4_io_port.sv
// TD4 I/O peripheral: host-written input register and change-capture FIFO on td4_out.
// TD4_IO_TIMESTAMP_EN adds a free-running cycle counter and the cap_ts port.
module td4_io_port
    import td4_io_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [3:0]               td4_out,
    output logic [3:0]               td4_in,
    input  logic                     wr_en,
    input  logic [3:0]               wr_data,
    output logic                     cap_valid,
    input  logic                     cap_ready,
    output logic [3:0]               cap_data,
`ifdef TD4_IO_TIMESTAMP_EN
    output logic [TS_W-1:0]          cap_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr
);

    nibble_t     out_q;
    nibble_t     last_q;
    logic        push_req;
    logic        pop;
    logic        full;
    logic        empty;
    cap_entry_t  push_entry;
    cap_entry_t  head;

    assign push_req  = (out_q != last_q);
    assign cap_valid = !empty;
    assign pop       = cap_valid && cap_ready;
    // Gate the head so a drained or flushed FIFO shows zero instead of stale data.
    assign cap_data  = cap_valid ? head.data : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            td4_in   <= '0;
            out_q    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) td4_in <= wr_data;
            out_q  <= td4_out;
            last_q <= out_q;
            if (clr)
                overflow <= 1'b0;
            else if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

`ifdef TD4_IO_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q;

    // ts_q follows out_q so each entry carries the cycle its value was sampled.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            ts_q   <= ts_cnt;
        end
    end

    assign cap_ts = cap_valid ? TS_W'(head.ts) : '0;
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.data = out_q;
`ifdef TD4_IO_TIMESTAMP_EN
        push_entry.ts   = TS_W_DEF'(ts_q);
`endif
    end

    td4_io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .clr   (clr),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_td4_io_port.sv
// Directed bench for td4_io_port: vector table plus hand-written multi-cycle sequences.
module tb_td4_io_port;
    import td4_io_pkg::*;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst_b;
    logic [3:0]     td4_out;
    logic [3:0]     td4_in;
    logic           wr_en;
    logic [3:0]     wr_data;
    logic           cap_valid;
    logic           cap_ready;
    logic [3:0]     cap_data;
`ifdef TD4_IO_TIMESTAMP_EN
    logic [TS_W-1:0] cap_ts;
`endif
    logic [CW-1:0]  count;
    logic           overflow;
    logic           clr;

    td4_io_port #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .td4_out   (td4_out),
        .td4_in    (td4_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
`ifdef TD4_IO_TIMESTAMP_EN
        .cap_ts    (cap_ts),
`endif
        .count     (count),
        .overflow  (overflow),
        .clr       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic    wr_en;
        nibble_t wr_data;
        nibble_t out;
        logic    rdy;
        logic    clr;
        nibble_t e_in;
        logic    e_valid;
        nibble_t e_data;
        int      e_count;
        logic    e_ov;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        nibble_t outs[6];
        nibble_t got[$];
        int      ts_got[$];
        int      first;
        nibble_t exp_c[8];

        vt[0]  = '{1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[1]  = '{1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[2]  = '{1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[3]  = '{1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 4'hA, 1'b1, 4'h3, 1, 1'b0};
        vt[4]  = '{1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 4'hA, 1'b1, 4'h3, 1, 1'b0};
        vt[5]  = '{1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 4'hA, 1'b1, 4'h3, 1, 1'b0};
        vt[6]  = '{1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 4'hA, 1'b1, 4'h3, 2, 1'b0};
        vt[7]  = '{1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 4'hA, 1'b1, 4'h5, 1, 1'b0};
        vt[8]  = '{1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[9]  = '{1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[10] = '{1'b0, 4'h0, 4'h9, 1'b0, 1'b0, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[11] = '{1'b0, 4'h0, 4'h9, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0};
        vt[12] = '{1'b1, 4'h6, 4'h9, 1'b0, 1'b0, 4'h6, 1'b0, 4'h0, 0, 1'b0};

        rst_b = 1'b0; td4_out = '0; wr_en = 1'b0; wr_data = '0;
        cap_ready = 1'b0; clr = 1'b0;
        #12;
        rst_b = 1'b1;

        // reset and idle
        repeat (20) tick();
        chk("idle_valid", int'(cap_valid), 0);
        chk("idle_count", int'(count), 0);
        chk("idle_td4_in", int'(td4_in), 0);
        chk("idle_overflow", int'(overflow), 0);
        chk("idle_data", int'(cap_data), 0);

        for (int i = 0; i < 13; i++) begin
            wr_en = vt[i].wr_en; wr_data = vt[i].wr_data; td4_out = vt[i].out;
            cap_ready = vt[i].rdy; clr = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_td4_in", i), int'(td4_in), int'(vt[i].e_in));
            chk($sformatf("vec%0d_valid", i), int'(cap_valid), int'(vt[i].e_valid));
            chk($sformatf("vec%0d_data", i), int'(cap_data), int'(vt[i].e_data));
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_count);
            chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vt[i].e_ov));
        end
        wr_en = 1'b0; clr = 1'b0; cap_ready = 1'b0;

        // 0->3->3->5 with the host always ready
        td4_out = '0;
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        tick();
        outs[0] = 4'h3; outs[1] = 4'h3; outs[2] = 4'h5;
        outs[3] = 4'h5; outs[4] = 4'h5; outs[5] = 4'h5;
        first = -1;
        cap_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            td4_out = outs[i];
            tick();
            if (cap_valid) begin
                got.push_back(cap_data);
`ifdef TD4_IO_TIMESTAMP_EN
                ts_got.push_back(int'(cap_ts));
`endif
                if (first < 0) first = i;
            end
        end
        chk("seq_entries", got.size(), 2);
        if (got.size() == 2) begin
            chk("seq_first_value", int'(got[0]), 3);
            chk("seq_second_value", int'(got[1]), 5);
        end
        chk("seq_first_valid_edge", first, 1);
`ifdef TD4_IO_TIMESTAMP_EN
        if (ts_got.size() == 2) chk("seq_ts_delta", ts_got[1] - ts_got[0], 2);
`endif
        chk("seq_count_end", int'(count), 0);

        // overflow: ten distinct changes, host not ready
        cap_ready = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            td4_out = 4'(i);
            tick();
        end
        tick(); tick();
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_head", int'(cap_data), 1);
        tick();
        chk("ovf_head_stable", int'(cap_data), 1);
        cap_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_order%0d", i), int'(cap_data), i + 1);
            tick();
        end
        cap_ready = 1'b0;
        chk("ovf_drained_count", int'(count), 0);
        chk("ovf_sticky", int'(overflow), 1);
        td4_out = 4'h3; tick(); tick();
        chk("pre_clr_count", int'(count), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_count", int'(count), 0);
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_valid", int'(cap_valid), 0);

        // full FIFO with simultaneous push and pop
        for (int i = 1; i <= 8; i++) begin
            td4_out = 4'(i);
            tick();
        end
        tick();
        chk("full_count", int'(count), 8);
        td4_out = 4'hC; tick();
        cap_ready = 1'b1; tick(); cap_ready = 1'b0;
        chk("pushpop_count", int'(count), 8);
        chk("pushpop_overflow", int'(overflow), 0);
        chk("pushpop_head", int'(cap_data), 2);
        exp_c[0] = 4'h2; exp_c[1] = 4'h3; exp_c[2] = 4'h4; exp_c[3] = 4'h5;
        exp_c[4] = 4'h6; exp_c[5] = 4'h7; exp_c[6] = 4'h8; exp_c[7] = 4'hC;
        cap_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pushpop_order%0d", i), int'(cap_data), int'(exp_c[i]));
            tick();
        end
        cap_ready = 1'b0;
        chk("pushpop_drained", int'(count), 0);

        // asynchronous reset mid-operation
        wr_en = 1'b1; wr_data = 4'h7; tick(); wr_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            td4_out = 4'(i);
            tick();
        end
        tick();
        chk("rst_pre_count", int'(count), 4);
        chk("rst_pre_valid", int'(cap_valid), 1);
        chk("rst_pre_td4_in", int'(td4_in), 7);
        td4_out = '0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_td4_in", int'(td4_in), 0);
        chk("rst_valid", int'(cap_valid), 0);
        chk("rst_data", int'(cap_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
`ifdef TD4_IO_TIMESTAMP_EN
        chk("rst_ts", int'(cap_ts), 0);
`endif
        #2;
        rst_b = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_valid", int'(cap_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
